avalon_mm_credit_shim: RTL and testbench

AVALON_MM_CREDIT_SHIM -- requirements
Module: avalon_mm_credit_shim

---
 rtl/avalon_mm_credit_shim.sv | 145 ++++++++++++++
 tb/tb_avalon_mm_credit_shim.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_credit_shim.sv
// NoC-to-Avalon-MM slave shim: decodes request packets into Avalon commands and returns
// read data through a credit-protected first-word-fall-through response FIFO.
module avalon_mm_credit_shim #(
  parameter int AVL_ADDR_WIDTH    = 29,
  parameter int AVL_DATA_WIDTH    = 512,
  parameter int AVL_BYTE_EN_WIDTH = AVL_DATA_WIDTH / 8,
  parameter int WIDTH_PKT         = 600,
  parameter int RSP_DEPTH         = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH_PKT-1:0]             nocs_data_in,
  input  logic                             nocs_valid_in,
  output logic                             nocs_ready_out,
  output logic [AVL_DATA_WIDTH-1:0]        avls_writedata,
  output logic [AVL_ADDR_WIDTH-1:0]        avls_address,
  output logic                             avls_write,
  output logic                             avls_read,
  output logic [AVL_BYTE_EN_WIDTH-1:0]     avls_byteenable,
  input  logic                             avls_waitrequest,
  input  logic [AVL_DATA_WIDTH-1:0]        avls_readdata,
  input  logic                             avls_readdatavalid,
  output logic [WIDTH_PKT-1:0]             nocs_data_out,
  output logic                             nocs_valid_out,
  input  logic                             nocs_ready_in,
  output logic [$clog2(RSP_DEPTH):0]       pending_cnt,
  output logic [$clog2(RSP_DEPTH):0]       outstanding_cnt,
  output logic                             err
);

  localparam int PTR_W    = $clog2(RSP_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int WR_BIT   = AVL_DATA_WIDTH + AVL_ADDR_WIDTH;
  localparam int RD_BIT   = WR_BIT + 1;
  localparam int BE_LSB   = WR_BIT + 2;
  localparam int FIELDS_W = BE_LSB + AVL_BYTE_EN_WIDTH;
  localparam int EXT_W    = (WIDTH_PKT > FIELDS_W) ? WIDTH_PKT : FIELDS_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  // A packet narrower than the full field layout reads its missing upper byteenable bits as zero.
  logic [EXT_W-1:0]          pkt_ext;
  logic                      req_wr;
  logic                      req_rd;
  logic                      credit_ok;
  logic                      issue;
  logic                      both_accept;
  logic                      rdv_ok;
  logic                      rdv_stray;
  logic                      push;
  logic                      pop;
  logic                      overflow;
  logic                      full;
  logic                      empty;
  logic [PTR_W:0]            wr_ptr;
  logic [PTR_W:0]            rd_ptr;
  logic [AVL_DATA_WIDTH-1:0] mem [RSP_DEPTH];

  assign pkt_ext         = EXT_W'(nocs_data_in);
  assign avls_writedata  = pkt_ext[AVL_DATA_WIDTH-1:0];
  assign avls_address    = pkt_ext[WR_BIT-1:AVL_DATA_WIDTH];
  assign avls_byteenable = pkt_ext[FIELDS_W-1:BE_LSB];
  assign req_wr          = pkt_ext[WR_BIT];
  assign req_rd          = pkt_ext[RD_BIT];

  generate
    if (EXT_W > FIELDS_W) begin : g_spare
      logic unused_hi;
      assign unused_hi = ^pkt_ext[EXT_W-1:FIELDS_W];
    end
  endgenerate

  assign credit_ok = (pending_cnt < DEPTH_C);

  // Command decode and handshake; a packet with both bits set is handled as a write.
  always_comb begin
    avls_write     = 1'b0;
    avls_read      = 1'b0;
    nocs_ready_out = 1'b1;
    if (req_wr) begin
      avls_write     = nocs_valid_in;
      nocs_ready_out = ~avls_waitrequest;
    end else if (req_rd) begin
      avls_read      = nocs_valid_in & credit_ok;
      nocs_ready_out = credit_ok & ~avls_waitrequest;
    end else begin
      nocs_ready_out = 1'b1;
    end
  end

  assign issue       = avls_read & ~avls_waitrequest;
  assign both_accept = nocs_valid_in & req_wr & req_rd & ~avls_waitrequest;
  assign rdv_ok      = avls_readdatavalid & (outstanding_cnt != {CNT_W{1'b0}});
  assign rdv_stray   = avls_readdatavalid & (outstanding_cnt == {CNT_W{1'b0}});

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop      = ~empty & nocs_ready_in;
  assign push     = rdv_ok & (~full | pop);
  assign overflow = rdv_ok & full & ~pop;

  assign nocs_valid_out = ~empty;
  // Gated with empty so the output reads as zero whenever nothing is buffered.
  assign nocs_data_out  = empty ? {WIDTH_PKT{1'b0}}
                                : {{(WIDTH_PKT-AVL_DATA_WIDTH){1'b0}}, mem[rd_ptr[PTR_W-1:0]]};

  // Response storage; contents are only observable through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= avls_readdata;
    end
  end

  // FIFO pointers, credit counters and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= {(PTR_W+1){1'b0}};
      rd_ptr          <= {(PTR_W+1){1'b0}};
      pending_cnt     <= {CNT_W{1'b0}};
      outstanding_cnt <= {CNT_W{1'b0}};
      err             <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
      end
      case ({issue, pop})
        2'b10:   pending_cnt <= pending_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   pending_cnt <= pending_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        default: pending_cnt <= pending_cnt;
      endcase
      case ({issue, rdv_ok})
        2'b10:   outstanding_cnt <= outstanding_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   outstanding_cnt <= outstanding_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        default: outstanding_cnt <= outstanding_cnt;
      endcase
      if (both_accept | rdv_stray | overflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_credit_shim.sv
// Scoreboard bench for avalon_mm_credit_shim at RSP_DEPTH=4, 32-bit data.
module tb_avalon_mm_credit_shim;

  localparam int AW = 29;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int PW = 72;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] nocs_data_in = '0;
  logic          nocs_valid_in = 1'b0;
  logic          nocs_ready_out;
  logic [DW-1:0] avls_writedata;
  logic [AW-1:0] avls_address;
  logic          avls_write;
  logic          avls_read;
  logic [BW-1:0] avls_byteenable;
  logic          avls_waitrequest = 1'b0;
  logic [DW-1:0] avls_readdata = '0;
  logic          avls_readdatavalid = 1'b0;
  logic [PW-1:0] nocs_data_out;
  logic          nocs_valid_out;
  logic          nocs_ready_in = 1'b0;
  logic [2:0]    pending_cnt;
  logic [2:0]    outstanding_cnt;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  avalon_mm_credit_shim #(
    .AVL_ADDR_WIDTH(AW), .AVL_DATA_WIDTH(DW), .AVL_BYTE_EN_WIDTH(BW),
    .WIDTH_PKT(PW), .RSP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .nocs_data_in(nocs_data_in), .nocs_valid_in(nocs_valid_in), .nocs_ready_out(nocs_ready_out),
    .avls_writedata(avls_writedata), .avls_address(avls_address), .avls_write(avls_write),
    .avls_read(avls_read), .avls_byteenable(avls_byteenable), .avls_waitrequest(avls_waitrequest),
    .avls_readdata(avls_readdata), .avls_readdatavalid(avls_readdatavalid),
    .nocs_data_out(nocs_data_out), .nocs_valid_out(nocs_valid_out), .nocs_ready_in(nocs_ready_in),
    .pending_cnt(pending_cnt), .outstanding_cnt(outstanding_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input logic wr, input logic rd, input logic [AW-1:0] a,
                                        input logic [DW-1:0] wd, input logic [BW-1:0] be);
    logic [PW-1:0] p;
    p = '0;
    p[DW-1:0]       = wd;
    p[DW+AW-1:DW]   = a;
    p[DW+AW]        = wr;
    p[DW+AW+1]      = rd;
    p[DW+AW+5:DW+AW+2] = be;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret_data(input logic [DW-1:0] d);
    avls_readdatavalid = 1'b1;
    avls_readdata      = d;
    exp_q.push_back(d);
    tick();
    avls_readdatavalid = 1'b0;
  endtask

  // Scoreboard: every accepted response must match the oldest expected read datum.
  always @(negedge clk) begin
    if (!rst && nocs_valid_out && nocs_ready_in) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 72'd1, 72'd0);
      else chk("rsp_data", nocs_data_out, {40'd0, exp_q.pop_front()});
    end
  end

  initial begin
    tick();
    chk("rst_pending", pending_cnt, 72'd0);
    chk("rst_outstanding", outstanding_cnt, 72'd0);
    chk("rst_valid", nocs_valid_out, 72'd0);
    chk("rst_err", err, 72'd0);
    rst = 1'b0;
    tick();

    // Four back-to-back reads exhaust the credits; the fifth is blocked.
    for (int i = 0; i < 4; i++) begin
      nocs_valid_in = 1'b1;
      nocs_data_in  = pkt(1'b0, 1'b1, AW'(32'h100 + i), 32'h0, 4'hF);
      #1;
      chk("read_issue", avls_read, 72'd1);
      chk("read_addr", avls_address, 72'h100 + 72'(i));
      tick();
    end
    chk("full_pending", pending_cnt, 72'd4);
    chk("full_outstanding", outstanding_cnt, 72'd4);
    nocs_data_in = pkt(1'b0, 1'b1, AW'(29'h104), 32'h0, 4'hF);
    #1;
    chk("blocked_ready", nocs_ready_out, 72'd0);
    chk("blocked_read", avls_read, 72'd0);

    // Return A0..A3, then drain in order while the fifth read gets its credit.
    for (int i = 0; i < 4; i++) ret_data(32'hA0 + 32'(i));
    chk("ret_outstanding", outstanding_cnt, 72'd0);
    chk("ret_pending", pending_cnt, 72'd4);
    chk("ret_head", nocs_data_out, 72'hA0);
    tick();
    chk("hold_valid", nocs_valid_out, 72'd1);
    chk("hold_head", nocs_data_out, 72'hA0);
    nocs_ready_in = 1'b1;
    tick();
    chk("pop1_pending", pending_cnt, 72'd3);
    chk("fifth_issue", avls_read, 72'd1);
    tick();
    chk("issue_pop_pending", pending_cnt, 72'd3);
    chk("fifth_outstanding", outstanding_cnt, 72'd1);
    nocs_valid_in = 1'b0;
    tick();
    tick();
    chk("drain_pending", pending_cnt, 72'd1);
    chk("drain_valid", nocs_valid_out, 72'd0);
    ret_data(32'hA4);
    tick();
    chk("final_pending", pending_cnt, 72'd0);
    nocs_ready_in = 1'b0;

    // Write stalled three cycles by waitrequest.
    avls_waitrequest = 1'b1;
    nocs_valid_in    = 1'b1;
    nocs_data_in     = pkt(1'b1, 1'b0, AW'(29'h55), 32'hCAFE_F00D, 4'h3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_stall_write", avls_write, 72'd1);
      chk("wr_stall_ready", nocs_ready_out, 72'd0);
      tick();
    end
    avls_waitrequest = 1'b0;
    #1;
    chk("wr_write", avls_write, 72'd1);
    chk("wr_ready", nocs_ready_out, 72'd1);
    chk("wr_data", avls_writedata, 72'hCAFE_F00D);
    chk("wr_be", avls_byteenable, 72'h3);
    tick();
    nocs_valid_in = 1'b0;
    chk("wr_pending", pending_cnt, 72'd0);
    chk("wr_outstanding", outstanding_cnt, 72'd0);

    // Neither command bit: discarded, always ready.
    nocs_valid_in = 1'b1;
    nocs_data_in  = pkt(1'b0, 1'b0, AW'(29'h7), 32'h1, 4'h1);
    #1;
    chk("nop_ready", nocs_ready_out, 72'd1);
    chk("nop_cmd", {avls_read, avls_write}, 72'd0);
    tick();
    nocs_valid_in = 1'b0;
    chk("nop_err", err, 72'd0);

    // Steady stream: issue, return and pop every cycle with two entries buffered.
    for (int i = 0; i < 3; i++) begin
      nocs_valid_in = 1'b1;
      nocs_data_in  = pkt(1'b0, 1'b1, AW'(29'h200 + i), 32'h0, 4'hF);
      tick();
    end
    nocs_valid_in = 1'b0;
    ret_data(32'hB0);
    ret_data(32'hB1);
    chk("stream_pre_pending", pending_cnt, 72'd3);
    chk("stream_pre_outstanding", outstanding_cnt, 72'd1);
    for (int k = 0; k < 20; k++) begin
      nocs_valid_in = 1'b1;
      nocs_data_in  = pkt(1'b0, 1'b1, AW'(29'h300 + k), 32'h0, 4'hF);
      nocs_ready_in = 1'b1;
      ret_data(32'hC000 + 32'(k));
      chk("stream_pending", pending_cnt, 72'd3);
      chk("stream_outstanding", outstanding_cnt, 72'd1);
    end
    nocs_valid_in = 1'b0;
    ret_data(32'hD0);
    for (int i = 0; i < 3; i++) tick();
    chk("stream_end_pending", pending_cnt, 72'd0);
    chk("stream_end_outstanding", outstanding_cnt, 72'd0);
    chk("stream_end_valid", nocs_valid_out, 72'd0);
    chk("stream_err", err, 72'd0);
    chk("stream_drained", 72'(exp_q.size()), 72'd0);
    nocs_ready_in = 1'b0;

    // Stray readdatavalid: dropped and flagged.
    avls_readdatavalid = 1'b1;
    avls_readdata      = 32'hDEAD;
    tick();
    avls_readdatavalid = 1'b0;
    chk("stray_err", err, 72'd1);
    chk("stray_valid", nocs_valid_out, 72'd0);
    tick();
    chk("stray_err_sticky", err, 72'd1);
    chk("stray_outstanding", outstanding_cnt, 72'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_err", err, 72'd0);

    // Both command bits: behaves as a write and sets the error flag.
    nocs_valid_in = 1'b1;
    nocs_data_in  = pkt(1'b1, 1'b1, AW'(29'h9), 32'h9, 4'hF);
    #1;
    chk("both_write", avls_write, 72'd1);
    chk("both_read", avls_read, 72'd0);
    tick();
    nocs_valid_in = 1'b0;
    chk("both_err", err, 72'd1);
    chk("both_pending", pending_cnt, 72'd0);

    // Asynchronous reset with three buffered and one outstanding.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nocs_valid_in = 1'b1;
      nocs_data_in  = pkt(1'b0, 1'b1, AW'(29'h400 + i), 32'h0, 4'hF);
      tick();
    end
    nocs_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) ret_data(32'hE0 + 32'(i));
    chk("pre_rst_outstanding", outstanding_cnt, 72'd1);
    chk("pre_rst_valid", nocs_valid_out, 72'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_pending", pending_cnt, 72'd0);
    chk("async_outstanding", outstanding_cnt, 72'd0);
    chk("async_valid", nocs_valid_out, 72'd0);
    chk("async_data", nocs_data_out, 72'd0);
    chk("async_err", err, 72'd0);
    tick();
    rst = 1'b0;
    tick();
    avls_readdatavalid = 1'b1;
    avls_readdata      = 32'hE3;
    tick();
    avls_readdatavalid = 1'b0;
    chk("late_rdv_err", err, 72'd1);
    chk("late_rdv_valid", nocs_valid_out, 72'd0);
    tick();
    chk("end_queue_empty", 72'(exp_q.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
